// File: rtl/cbus_sram_pkg.sv
// Shared types and constants for the cbus SRAM responder.
package cbus_sram_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } cbus_sram_state_t;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  // Low address bits that must be zero for sizes 1/2/4/8 bytes (encodings 0..3).
  localparam logic [3:0][2:0] ALIGN_MASK = {3'b111, 3'b011, 3'b001, 3'b000};

endpackage

// File: rtl/sram_bank.sv
// WORDS x 64-bit storage: one synchronous byte-enable write port, one combinational read port.
module sram_bank
  import cbus_sram_pkg::*;
#(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned AW    = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [STRB_W-1:0] strobe,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  // Contents are deliberately not reset so they survive a bus reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (strobe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cbus_sram.sv
// cbus responder with programmable latency backed by sram_bank.
// Optional address/alignment error reporting is enabled by defining CBUS_SRAM_ERR_EN.
module cbus_sram
  import cbus_sram_pkg::*;
#(
  parameter int unsigned       WORDS   = 4096,
  parameter int unsigned       LATENCY = 2,
  parameter logic [ADDR_W-1:0] BASE    = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       err
);

  localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  cbus_sram_state_t  state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  cbus_req_t         cap, cap_n;
  cbus_resp_t        resp_n;
  logic              err_n;

  logic [ADDR_W-1:0] rd_off, wr_off;
  logic [AW-1:0]     rd_idx, wr_idx;
  logic [DATA_W-1:0] rd_data;
  logic [STRB_W-1:0] wr_strb;
  logic              we;

`ifdef CBUS_SRAM_ERR_EN
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(WORDS) << 3;

  function automatic logic req_err(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
    logic [ADDR_W-1:0] off;
    off = addr - BASE;
    return (addr < BASE) || (off >= SPAN) || ((addr[2:0] & ALIGN_MASK[size]) != 3'b000);
  endfunction
`endif

  // Read index follows the request that will occupy RESP next, so the
  // response data can be registered on the edge that enters RESP.
  assign rd_off  = cap_n.addr - BASE;
  assign rd_idx  = rd_off[AW+2:3];
  assign wr_off  = cap.addr - BASE;
  assign wr_idx  = wr_off[AW+2:3];
  assign wr_strb = cap.is_write ? cap.strobe : STRB_W'(0);
  assign we      = (state == RESP) && !err && !reset;

  logic unused_bits;
  assign unused_bits = ^{rd_off[ADDR_W-1:AW+3], rd_off[2:0], wr_off[ADDR_W-1:AW+3],
                         wr_off[2:0], cap.valid, cap.size};

  sram_bank #(
    .WORDS(WORDS),
    .AW   (AW)
  ) u_bank (
    .clk   (clk),
    .we    (we),
    .strobe(wr_strb),
    .waddr (wr_idx),
    .wdata (cap.data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= '0;
      cresp <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cap   <= cap_n;
      cresp <= resp_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_n   = cap;
    resp_n  = '0;
    err_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (creq.valid) begin
          cap_n   = creq;
          cnt_n   = CNT_W'(LATENCY - 1);
          state_n = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = RESP;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Response fields are prepared one cycle early and held for the RESP cycle.
    if (state_n == RESP) begin
`ifdef CBUS_SRAM_ERR_EN
      err_n = req_err(cap_n.addr, cap_n.size);
`endif
      resp_n.ready = 1'b1;
      resp_n.last  = 1'b1;
      resp_n.data  = err_n ? DATA_W'(0) : rd_data;
    end
  end

endmodule

// File: tb/tb_cbus_sram.sv
// Scoreboard bench for cbus_sram: expectations queued at issue, checked on ready.
module tb_cbus_sram;
  import cbus_sram_pkg::*;

  localparam int unsigned       WORDS   = 4096;
  localparam int unsigned       LATENCY = 2;
  localparam logic [63:0]       BASE    = 64'h8000_0000;
`ifdef CBUS_SRAM_ERR_EN
  localparam bit                ERR_EN  = 1'b1;
`else
  localparam bit                ERR_EN  = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic        chk;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       err;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  exp_t        sb[$];
  logic [63:0] model [int];

  cbus_sram #(
    .WORDS  (WORDS),
    .LATENCY(LATENCY),
    .BASE   (BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .creq (creq),
    .cresp(cresp),
    .err  (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: every ready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cresp.ready) begin
        check_eq("ready_has_expectation", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("last", 64'(cresp.last), 64'd1);
          check_eq("err", 64'(err), 64'(e.err));
          check_eq("ready_cycle", 64'(cyc), 64'(e.cyc));
          if (e.chk) check_eq("data", cresp.data, e.data);
        end
      end else begin
        check_eq("idle_data", cresp.data, 64'd0);
        check_eq("idle_last_err", 64'({cresp.last, err}), 64'd0);
      end
    end
  end

  function automatic int word_idx(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE;
    return int'((off >> 3) % 64'(WORDS));
  endfunction

  function automatic bit addr_bad(input logic [63:0] addr, input logic [1:0] sz);
    logic [63:0] amask;
    amask = (64'd1 << sz) - 64'd1;
    return (addr < BASE) || (addr >= BASE + 64'(WORDS) * 64'd8) || ((addr & amask) != 64'd0);
  endfunction

  task automatic push_exp(input logic wr, input logic [1:0] sz, input logic [63:0] addr,
                          input logic [7:0] stb, input logic [63:0] wd, input bit chk, input int at);
    exp_t        e;
    int          idx;
    logic [63:0] w;
    idx   = word_idx(addr);
    e.err = ERR_EN && addr_bad(addr, sz);
    w     = model.exists(idx) ? model[idx] : 64'd0;
    e.data = e.err ? 64'd0 : w;
    e.chk  = chk || e.err;
    e.cyc  = at;
    if (wr && !e.err) begin
      for (int b = 0; b < 8; b++) if (stb[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      model[idx] = w;
    end
    sb.push_back(e);
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz, input logic [63:0] addr,
                       input logic [7:0] stb, input logic [63:0] wd);
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = sz;
    creq.addr     = addr;
    creq.strobe   = stb;
    creq.data     = wd;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check_eq("drain", 64'(sb.size()), 64'd0);
    #1;
  endtask

  // One isolated transaction; valid drops after a single cycle.
  task automatic send(input logic wr, input logic [1:0] sz, input logic [63:0] addr,
                      input logic [7:0] stb, input logic [63:0] wd, input bit chk);
    push_exp(wr, sz, addr, stb, wd, chk, cyc + int'(LATENCY));
    drive(wr, sz, addr, stb, wd);
    @(posedge clk); #1;
    creq.valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    reset = 1'b1;
    creq  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(cresp.ready), 64'd0);
    check_eq("rst_last", 64'(cresp.last), 64'd0);
    check_eq("rst_data", cresp.data, 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Preload words 0..4; old contents are unknown so their data is not checked.
    send(1'b1, 2'd3, BASE, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
    for (int i = 1; i < 5; i++) send(1'b1, 2'd3, BASE + 64'(i) * 8, 8'hFF, 64'd0, 1'b0);

    send(1'b0, 2'd3, BASE, 8'h00, 64'd0, 1'b1);
    send(1'b1, 2'd3, BASE + 8, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send(1'b0, 2'd3, BASE + 8, 8'h00, 64'd0, 1'b1);
    check_eq("model_strobed", model[1], 64'h0000_0000_FFFF_FFFF);

    // Page-table style: write flag with no strobes leaves the word intact.
    send(1'b1, 2'd3, BASE, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
    send(1'b0, 2'd3, BASE, 8'h00, 64'd0, 1'b1);

    // Back-to-back chain with valid held high.
    c = cyc;
    push_exp(1'b0, 2'd3, BASE + 16, 8'h00, 64'd0, 1'b1, c + int'(LATENCY));
    drive(1'b0, 2'd3, BASE + 16, 8'h00, 64'd0);
    repeat (LATENCY + 1) @(posedge clk);
    #1;
    push_exp(1'b1, 2'd3, BASE + 24, 8'hF0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b1, c + 2 * int'(LATENCY) + 1);
    drive(1'b1, 2'd3, BASE + 24, 8'hF0, 64'hA5A5_A5A5_5A5A_5A5A);
    @(posedge clk); #1;
    creq.valid = 1'b0;
    wait_drain();
    send(1'b0, 2'd3, BASE + 24, 8'h00, 64'd0, 1'b1);

    // Reset during WAIT of a write: no response and no write.
    drive(1'b1, 2'd3, BASE + 32, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD);
    @(posedge clk); #1;
    creq.valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(1'b0, 2'd3, BASE + 32, 8'h00, 64'd0, 1'b1);

    // Reset coincident with valid: nothing captured.
    reset = 1'b1;
    drive(1'b1, 2'd3, BASE + 32, 8'hFF, 64'h1234_5678_9ABC_DEF0);
    @(posedge clk); #1;
    reset = 1'b0;
    creq.valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(1'b0, 2'd3, BASE + 32, 8'h00, 64'd0, 1'b1);

`ifdef CBUS_SRAM_ERR_EN
    send(1'b0, 2'd3, 64'h7FFF_FFF8, 8'h00, 64'd0, 1'b1);
    send(1'b1, 2'd2, 64'h8000_0002, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE, 1'b1);
    send(1'b1, 2'd3, BASE + 64'(WORDS) * 8, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE, 1'b1);
    send(1'b0, 2'd3, BASE, 8'h00, 64'd0, 1'b1);
`else
    send(1'b0, 2'd3, BASE + 64'(WORDS) * 8, 8'h00, 64'd0, 1'b1);
    send(1'b1, 2'd3, BASE + 64'(WORDS) * 8 + 8, 8'h3C, 64'h0102_0304_0506_0708, 1'b1);
    send(1'b0, 2'd3, BASE + 8, 8'h00, 64'd0, 1'b1);
`endif

    // Mixed traffic over the preloaded words, including sub-word offsets.
    for (int i = 0; i < 12; i++) begin
      logic [63:0] a;
      a = BASE + 64'($urandom_range(0, 4)) * 8 + 64'($urandom_range(0, 7));
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, 8'($urandom),
           {$urandom, $urandom}, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
